// File: rtl/fp32_add_align.sv
// fp32_add_align: two-stage FP32 operand ordering and significand alignment with sticky folding
module fp32_add_align #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [31:0]       A,
    input  logic [31:0]       B,
    input  logic              Sub,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic              Sign_L,
    output logic              Eff_Sub,
    output logic [EXP_W-1:0]  Exp_L,
    output logic [FRAC_W+3:0] Man_L,
    output logic [FRAC_W+3:0] Man_S,
    output logic              Is_NaN,
    output logic              Is_Inf,
    output logic              Swapped
);
    localparam int MW = FRAC_W + 4;
    logic v1, v2, ld1, ld2, swap, nan_a, nan_b, inf_a, inf_b, eff_sub, sign_l, is_nan, is_inf;
    logic [31:0] op_l, op_s;
    logic [EXP_W-1:0] exp_l, exp_s, d, s1_exp, s1_d;
    logic [MW-1:0] man_l, man_s, s1_man_l, s1_man_s, shifted;
    logic [2*MW-1:0] ext;
    logic s1_sign, s1_eff_sub, s1_nan, s1_inf, s1_swap;
    always_comb begin
        ld2 = !v2 || Out_Ready;
        ld1 = !v1 || ld2;
        In_Ready = ld1;
        Out_Valid = v2;
        swap = B[30:0] > A[30:0];
        op_l = swap ? B : A;
        op_s = swap ? A : B;
        exp_l = (op_l[FRAC_W+:EXP_W] == '0) ? EXP_W'(1) : op_l[FRAC_W+:EXP_W];
        exp_s = (op_s[FRAC_W+:EXP_W] == '0) ? EXP_W'(1) : op_s[FRAC_W+:EXP_W];
        man_l = {|op_l[FRAC_W+:EXP_W], op_l[FRAC_W-1:0], 3'b000};
        man_s = {|op_s[FRAC_W+:EXP_W], op_s[FRAC_W-1:0], 3'b000};
        d = exp_l - exp_s;
        nan_a = (&A[FRAC_W+:EXP_W]) && (|A[FRAC_W-1:0]);
        nan_b = (&B[FRAC_W+:EXP_W]) && (|B[FRAC_W-1:0]);
        inf_a = (&A[FRAC_W+:EXP_W]) && !(|A[FRAC_W-1:0]);
        inf_b = (&B[FRAC_W+:EXP_W]) && !(|B[FRAC_W-1:0]);
        eff_sub = A[31] ^ B[31] ^ Sub;
        sign_l = swap ? B[31] ^ Sub : A[31];
        is_nan = nan_a || nan_b || (inf_a && inf_b && eff_sub);
        is_inf = !is_nan && (inf_a || inf_b);
        // Lower half of ext collects every bit shifted past the LSB; it all folds into sticky.
        ext = {s1_man_s, {MW{1'b0}}} >> s1_d;
        shifted = (s1_d >= EXP_W'(MW)) ? {{(MW-1){1'b0}}, |s1_man_s}
                                       : {ext[2*MW-1:MW+1], ext[MW] | (|ext[MW-1:0])};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            s1_sign <= 1'b0;
            s1_eff_sub <= 1'b0;
            s1_nan <= 1'b0;
            s1_inf <= 1'b0;
            s1_swap <= 1'b0;
            s1_exp <= '0;
            s1_d <= '0;
            s1_man_l <= '0;
            s1_man_s <= '0;
            Sign_L <= 1'b0;
            Eff_Sub <= 1'b0;
            Exp_L <= '0;
            Man_L <= '0;
            Man_S <= '0;
            Is_NaN <= 1'b0;
            Is_Inf <= 1'b0;
            Swapped <= 1'b0;
        end else begin
            if (ld1) begin
                v1 <= In_Valid;
                if (In_Valid) begin
                    s1_sign <= sign_l;
                    s1_eff_sub <= eff_sub;
                    s1_nan <= is_nan;
                    s1_inf <= is_inf;
                    s1_swap <= swap;
                    s1_exp <= exp_l;
                    s1_d <= d;
                    s1_man_l <= man_l;
                    s1_man_s <= man_s;
                end
            end
            if (ld2) begin
                v2 <= v1;
                if (v1) begin
                    Sign_L <= s1_sign;
                    Eff_Sub <= s1_eff_sub;
                    Exp_L <= s1_exp;
                    Man_L <= s1_man_l;
                    Man_S <= shifted;
                    Is_NaN <= s1_nan;
                    Is_Inf <= s1_inf;
                    Swapped <= s1_swap;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp32_add_align.sv
// tb_fp32_add_align: directed vectors, stall/reset sequences and a scoreboarded random run
module tb_fp32_add_align;
    typedef struct packed {
        logic        sign_l;
        logic        eff_sub;
        logic [7:0]  exp_l;
        logic [26:0] man_l;
        logic [26:0] man_s;
        logic        is_nan;
        logic        is_inf;
        logic        swapped;
    } res_t;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        res_t        want;
    } vec_t;

    logic clk = 1'b0, reset, In_Valid, In_Ready, Sub, Out_Valid, Out_Ready;
    logic Sign_L, Eff_Sub, Is_NaN, Is_Inf, Swapped;
    logic [31:0] A, B;
    logic [7:0] Exp_L;
    logic [26:0] Man_L, Man_S;
    res_t dut;
    int checks = 0, errors = 0, n_in = 0, n_out = 0;
    res_t q[$];
    vec_t vt[$];
    logic held = 1'b0;
    res_t held_res;

    fp32_add_align #(.EXP_W(8), .FRAC_W(23)) u_dut (
        .clk(clk), .reset(reset), .In_Valid(In_Valid), .In_Ready(In_Ready), .A(A), .B(B), .Sub(Sub),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Sign_L(Sign_L), .Eff_Sub(Eff_Sub), .Exp_L(Exp_L),
        .Man_L(Man_L), .Man_S(Man_S), .Is_NaN(Is_NaN), .Is_Inf(Is_Inf), .Swapped(Swapped)
    );

    always #5 clk = ~clk;
    assign dut = {Sign_L, Eff_Sub, Exp_L, Man_L, Man_S, Is_NaN, Is_Inf, Swapped};

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic res_t mk(input logic sl, es, input logic [7:0] el, input logic [26:0] ml, ms,
                                input logic n, i, sw);
        return {sl, es, el, ml, ms, n, i, sw};
    endfunction

    // Reference: align the smaller significand one bit at a time, accumulating sticky.
    function automatic res_t model(input logic [31:0] a, b, input logic sub);
        res_t r;
        logic [31:0] l, s;
        logic [7:0] el, es;
        logic [26:0] m;
        logic st, na, nb, ia, ib;
        int d;
        r.swapped = b[30:0] > a[30:0];
        l = r.swapped ? b : a;
        s = r.swapped ? a : b;
        r.eff_sub = a[31] ^ b[31] ^ sub;
        r.sign_l = r.swapped ? (b[31] ^ sub) : a[31];
        el = (l[30:23] == 8'd0) ? 8'd1 : l[30:23];
        es = (s[30:23] == 8'd0) ? 8'd1 : s[30:23];
        r.exp_l = el;
        r.man_l = {l[30:23] != 8'd0, l[22:0], 3'b000};
        m = {s[30:23] != 8'd0, s[22:0], 3'b000};
        st = 1'b0;
        d = int'(el) - int'(es);
        for (int i = 0; i < d; i++) begin
            st = st | m[0];
            m = m >> 1;
        end
        m[0] = m[0] | st;
        r.man_s = m;
        na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        r.is_nan = na || nb || (ia && ib && r.eff_sub);
        r.is_inf = !r.is_nan && (ia || ib);
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            held = 1'b0;
        end else begin
            if (held) chk("hold_stable", 128'({Out_Valid, dut}), 128'({1'b1, held_res}));
            if (Out_Valid && Out_Ready) begin
                n_out++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected no output", dut);
                end else chk("scoreboard", 128'(dut), 128'(q.pop_front()));
            end
            if (In_Valid && In_Ready) begin
                q.push_back(model(A, B, Sub));
                n_in++;
            end
            held = Out_Valid && !Out_Ready;
            held_res = dut;
        end
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] sa[4];
        logic [31:0] ra, rb;
        int idx, n0, t;
        sa = '{32'h3F800000, 32'h40400000, 32'hC1200000, 32'h00000007};
        vt.push_back('{32'h3F800000, 32'h40000000, 1'b0, mk(0, 0, 8'h80, 27'h4000000, 27'h2000000, 0, 0, 1)});
        vt.push_back('{32'h3F800000, 32'h33800000, 1'b0, mk(0, 0, 8'h7F, 27'h4000000, 27'h0000004, 0, 0, 0)});
        vt.push_back('{32'h3F800000, 32'h00000001, 1'b0, mk(0, 0, 8'h7F, 27'h4000000, 27'h0000001, 0, 0, 0)});
        vt.push_back('{32'h3F800000, 32'h3F800000, 1'b1, mk(0, 1, 8'h7F, 27'h4000000, 27'h4000000, 0, 0, 0)});
        vt.push_back('{32'h7F800000, 32'h7F800000, 1'b1, mk(0, 1, 8'hFF, 27'h4000000, 27'h4000000, 1, 0, 0)});
        vt.push_back('{32'h7F800000, 32'h7F800000, 1'b0, mk(0, 0, 8'hFF, 27'h4000000, 27'h4000000, 0, 1, 0)});
        vt.push_back('{32'h7FC00000, 32'h3F800000, 1'b0, mk(0, 0, 8'hFF, 27'h6000000, 27'h0000001, 1, 0, 0)});
        vt.push_back('{32'h40400000, 32'hC0A00000, 1'b1, mk(0, 0, 8'h81, 27'h5000000, 27'h3000000, 0, 0, 1)});
        vt.push_back('{32'h3F800000, 32'h33800001, 1'b0, mk(0, 0, 8'h7F, 27'h4000000, 27'h0000005, 0, 0, 0)});
        vt.push_back('{32'h00000003, 32'h00000001, 1'b0, mk(0, 0, 8'h01, 27'h0000018, 27'h0000008, 0, 0, 0)});
        vt.push_back('{32'hBF800000, 32'h3F800000, 1'b0, mk(1, 1, 8'h7F, 27'h4000000, 27'h4000000, 0, 0, 0)});
        vt.push_back('{32'h3F800000, 32'h33000000, 1'b0, mk(0, 0, 8'h7F, 27'h4000000, 27'h0000002, 0, 0, 0)});
        vt.push_back('{32'h3F800000, 32'h32800000, 1'b0, mk(0, 0, 8'h7F, 27'h4000000, 27'h0000001, 0, 0, 0)});
        vt.push_back('{32'h3F800000, 32'h32000000, 1'b0, mk(0, 0, 8'h7F, 27'h4000000, 27'h0000001, 0, 0, 0)});
        vt.push_back('{32'hFF800000, 32'h3F800000, 1'b0, mk(1, 1, 8'hFF, 27'h4000000, 27'h0000001, 0, 1, 0)});
        vt.push_back('{32'h3F800000, 32'hFF800000, 1'b1, mk(0, 0, 8'hFF, 27'h4000000, 27'h0000001, 0, 1, 1)});
        vt.push_back('{32'h00000000, 32'h80000000, 1'b1, mk(0, 0, 8'h01, 27'h0000000, 27'h0000000, 0, 0, 0)});
        vt.push_back('{32'h7F800001, 32'hFF800000, 1'b0, mk(0, 1, 8'hFF, 27'h4000008, 27'h4000000, 1, 0, 0)});

        reset = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b0; A = '0; B = '0; Sub = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_state", 128'({Out_Valid, In_Ready, dut}), 128'({1'b0, 1'b1, 67'd0}));

        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clk);
            #1 A = vt[i].a; B = vt[i].b; Sub = vt[i].sub; In_Valid = 1'b1; Out_Ready = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), 128'(In_Ready), 128'(1));
            @(posedge clk);
            #1 In_Valid = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_latency1", i), 128'(Out_Valid), 128'(0));
            @(negedge clk);
            chk($sformatf("vec%0d_latency2", i), 128'(Out_Valid), 128'(1));
            chk($sformatf("vec%0d", i), 128'(dut), 128'(vt[i].want));
        end

        @(posedge clk);
        #1 Out_Ready = 1'b0; Sub = 1'b0; B = 32'h3F800000; idx = 0; n0 = n_out;
        for (int c = 0; c < 6; c++) begin
            A = sa[idx]; In_Valid = 1'b1;
            @(negedge clk);
            t = int'(In_Ready);
            @(posedge clk);
            #1 if (t != 0) idx++;
        end
        chk("stall_accepted", 128'(idx), 128'(2));
        chk("stall_in_ready", 128'(In_Ready), 128'(0));
        Out_Ready = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            A = sa[idx];
            @(negedge clk);
            t = int'(In_Ready);
            @(posedge clk);
            #1 if (t != 0) idx++;
        end
        In_Valid = 1'b0;
        chk("stall_all_accepted", 128'(idx), 128'(4));
        for (int c = 0; c < 20 && q.size() != 0; c++) @(negedge clk);
        chk("stall_drained", 128'(q.size()), 128'(0));
        chk("stall_out_count", 128'(n_out - n0), 128'(4));

        @(posedge clk);
        #1 n0 = n_in;
        for (int c = 0; c < 60000 && n_in < n0 + 10000; c++) begin
            ra = $urandom;
            if ($urandom_range(0, 9) == 0) ra[30:23] = 8'hFF;
            case ($urandom_range(0, 4))
                0: rb = $urandom;
                1: rb = {1'($urandom_range(0, 1)), ra[30:23] - 8'($urandom_range(0, 30)), 23'($urandom)};
                2: rb = {1'($urandom_range(0, 1)), 8'hFF, ($urandom_range(0, 1) == 0) ? 23'd0 : 23'($urandom)};
                3: rb = ra ^ {1'($urandom_range(0, 1)), 30'd0, 1'($urandom_range(0, 1))};
                default: rb = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 2)), 23'($urandom)};
            endcase
            A = ra; B = rb; Sub = 1'($urandom_range(0, 1));
            In_Valid = ($urandom_range(0, 3) != 0);
            Out_Ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        In_Valid = 1'b0; Out_Ready = 1'b1;
        chk("random_in_count", 128'(n_in - n0), 128'(10000));
        for (int c = 0; c < 20 && q.size() != 0; c++) @(negedge clk);
        chk("random_drained", 128'(q.size()), 128'(0));

        @(posedge clk);
        #1 Out_Ready = 1'b0; In_Valid = 1'b1; A = 32'h40000000; B = 32'h3F800000; Sub = 1'b1;
        @(posedge clk);
        #1 A = 32'h40400000;
        @(posedge clk);
        #1 chk("full_out_valid", 128'(Out_Valid), 128'(1));
        chk("full_in_ready", 128'(In_Ready), 128'(0));
        In_Valid = 1'b0; reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("post_reset", 128'({Out_Valid, In_Ready, dut}), 128'({1'b0, 1'b1, 67'd0}));
        n0 = n_out; Out_Ready = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("no_stale_output", 128'(n_out - n0), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
